// File: rtl/interval_scheduler_if.sv
// Signal bundle between the configuration/counter side (master) and the
// interval scheduler (slave). Clock and reset stay outside as plain ports.
interface interval_scheduler_if #(
   parameter int IDX_W      = 2,
   parameter int INTERVAL_W = 16,
   parameter int COUNT_W    = 21
);
   logic                  start;
   logic                  stop;
   logic                  hold;
   logic                  loop_en;
   logic                  cfg_we;
   logic [IDX_W-1:0]      cfg_addr;
   logic [INTERVAL_W-1:0] cfg_data;
   logic                  ctr_switch;
   logic [COUNT_W-1:0]    ctr_count;
   logic [INTERVAL_W-1:0] ctr_interval;
   logic                  ctr_interval_reset;
   logic                  ctr_enable;
   logic [IDX_W-1:0]      phase;
   logic                  busy;
   logic                  warn;
   logic                  phase_done;
   logic                  seq_done;
   logic                  cfg_err;

   modport master (
      output start, stop, hold, loop_en, cfg_we, cfg_addr, cfg_data,
             ctr_switch, ctr_count,
      input  ctr_interval, ctr_interval_reset, ctr_enable, phase, busy, warn,
             phase_done, seq_done, cfg_err
   );

   modport slave (
      input  start, stop, hold, loop_en, cfg_we, cfg_addr, cfg_data,
             ctr_switch, ctr_count,
      output ctr_interval, ctr_interval_reset, ctr_enable, phase, busy, warn,
             phase_done, seq_done, cfg_err
   );
endinterface

// File: rtl/interval_scheduler.sv
// Phase sequencer for one interval counter: walks a table of phase durations,
// reloads the counter for each phase and advances on its terminal count.
module interval_scheduler #(
   parameter int N_PHASES    = 4,
   parameter int IDX_W       = 2,
   parameter int INTERVAL_W  = 16,
   parameter int COUNT_W     = 21,
   parameter int DEFAULT_MIN = 1
) (
   input logic                 clock,
   input logic                 reset_n,
   interval_scheduler_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT} state_e;

   localparam logic [IDX_W:0]        SKIP_ALL    = (IDX_W+1)'(N_PHASES);
   localparam logic [IDX_W-1:0]      LAST_PHASE  = IDX_W'(N_PHASES - 1);
   localparam logic [COUNT_W-1:0]    SEC_PER_MIN = COUNT_W'(60);
   localparam logic [INTERVAL_W-1:0] RESET_LEN   = INTERVAL_W'(DEFAULT_MIN);

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      phase_q, phase_d;
   logic [IDX_W:0]        skip_q, skip_d;
   logic [COUNT_W-1:0]    term_q, term_d;
   logic                  phase_done_q, phase_done_d;
   logic                  seq_done_q, seq_done_d;
   logic                  cfg_err_q, cfg_err_d;
   logic [INTERVAL_W-1:0] table_q [N_PHASES];

   logic [INTERVAL_W-1:0] cur_len;
   logic                  ctr_en;
   logic                  term_hit;

   assign cur_len  = table_q[phase_q];
   assign ctr_en   = (state_q == S_RUN) && !bus.hold;
   assign term_hit = ctr_en && (bus.ctr_count == term_q);

   // NOTE: the phase table sits on the async reset like the rest of the state,
   // so a reset mid-sequence restores every entry to the default duration.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_PHASES; i++) table_q[i] <= RESET_LEN;
      end else if (bus.cfg_we && (int'(bus.cfg_addr) < N_PHASES)) begin
         table_q[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the values from before the clock edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         phase_q      <= '0;
         skip_q       <= '0;
         term_q       <= '0;
         phase_done_q <= 1'b0;
         seq_done_q   <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         skip_q       <= skip_d;
         term_q       <= term_d;
         phase_done_q <= phase_done_d;
         seq_done_q   <= seq_done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      skip_d       = skip_q;
      term_d       = term_q;
      phase_done_d = 1'b0;
      seq_done_d   = 1'b0;
      cfg_err_d    = 1'b0;

      if (bus.stop) begin
         state_d = S_IDLE;
         phase_d = '0;
         skip_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
               if (cur_len == '0) begin
                  skip_d  = skip_q + 1'b1;
                  state_d = S_NEXT;
               end else begin
                  term_d  = COUNT_W'(cur_len) * SEC_PER_MIN - COUNT_W'(1);
                  skip_d  = '0;
                  state_d = S_RUN;
               end
            end
            S_RUN: begin
               if (term_hit) begin
                  phase_done_d = 1'b1;
                  state_d      = S_NEXT;
               end
            end
            S_NEXT: begin
               // An all-zero table would otherwise spin through LOAD/NEXT forever.
               if (skip_q == SKIP_ALL) begin
                  cfg_err_d = 1'b1;
                  phase_d   = '0;
                  skip_d    = '0;
                  state_d   = S_IDLE;
               end else if ((phase_q == LAST_PHASE) && !bus.loop_en) begin
                  seq_done_d = 1'b1;
                  phase_d    = '0;
                  skip_d     = '0;
                  state_d    = S_IDLE;
               end else begin
                  phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + 1'b1;
                  state_d = S_LOAD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign bus.ctr_interval       = cur_len;
   assign bus.ctr_interval_reset = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign bus.ctr_enable         = ctr_en;
   assign bus.phase              = phase_q;
   assign bus.busy               = (state_q != S_IDLE);
   assign bus.warn               = bus.ctr_switch && (state_q == S_RUN);
   assign bus.phase_done         = phase_done_q;
   assign bus.seq_done           = seq_done_q;
   assign bus.cfg_err            = cfg_err_q;
endmodule

// File: tb/tb_interval_scheduler.sv
// Self-checking bench for interval_scheduler: a cycle timeline built from the
// phase-table rules is compared against the scheduler driving a counter stand-in.
module tb_interval_scheduler;
   localparam int N = 4;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   interval_scheduler_if #(.IDX_W(2), .INTERVAL_W(16), .COUNT_W(21)) bus ();

   interval_scheduler #(
      .N_PHASES(N), .IDX_W(2), .INTERVAL_W(16), .COUNT_W(21), .DEFAULT_MIN(1)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   // Counter stand-in: clears and latches the interval on reload, wraps after interval*60 ticks.
   logic [20:0] cnt_q;
   logic [15:0] len_q;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         len_q <= '0;
      end else if (bus.ctr_interval_reset) begin
         cnt_q <= '0;
         len_q <= bus.ctr_interval;
      end else if (bus.ctr_enable) begin
         cnt_q <= (int'(cnt_q) == int'(len_q) * 60 - 1) ? '0 : cnt_q + 1'b1;
      end
   end
   assign bus.ctr_count = cnt_q;

   typedef struct {
      logic        run, en, ireset, busy, pdone, sdone, cerr;
      logic [1:0]  phase;
      logic [15:0] interval;
   } cyc_t;

   cyc_t exp_q[$];
   int   tab [N];
   bit   loop_m;
   int   hold_s, hold_len, w_cyc, w_addr, w_data, stop_cyc, max_cyc;
   int   cnt_a, cnt_b;
   int   tests_run = 0;
   int   tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int len_at(int ph, int idx);
      return (w_cyc > 0 && ph == w_addr && idx > w_cyc) ? w_data : tab[ph];
   endfunction

   function automatic bit hold_at(int idx);
      return (idx >= hold_s) && (idx < hold_s + hold_len);
   endfunction

   function automatic void push(bit run, bit en, bit ir, bit bz, int ph, int idx,
                                bit pd, bit sd, bit ce);
      cyc_t e;
      e.run = run; e.en = en; e.ireset = ir; e.busy = bz;
      e.pdone = pd; e.sdone = sd; e.cerr = ce;
      e.phase = 2'(ph);
      e.interval = 16'(len_at(ph, idx));
      exp_q.push_back(e);
   endfunction

   // Expected timeline, one entry per cycle after start is sampled (entry 0 = cycle 1).
   function automatic void build_model();
      int ph = 0, streak = 0, idx = 1, l, need;
      bit done = 1'b0;
      exp_q.delete();
      while (!done && idx <= max_cyc) begin
         l = len_at(ph, idx);
         push(0, 0, 1, 1, ph, idx, 0, 0, 0); idx++;
         if (l == 0) streak++;
         else begin
            streak = 0;
            need   = l * 60;
            while (need > 0) begin
               push(1, !hold_at(idx), 0, 1, ph, idx, 0, 0, 0);
               if (!hold_at(idx)) need--;
               idx++;
            end
         end
         push(0, 0, 0, 1, ph, idx, (l != 0), 0, 0); idx++;
         if (streak == N) begin
            push(0, 0, 1, 0, 0, idx, 0, 0, 1); done = 1'b1;
         end else if (ph == N - 1 && !loop_m) begin
            push(0, 0, 1, 0, 0, idx, 0, 1, 0); done = 1'b1;
         end else ph = (ph + 1) % N;
      end
      if (stop_cyc > 0) begin
         while (exp_q.size() > stop_cyc) void'(exp_q.pop_back());
         push(0, 0, 1, 0, 0, stop_cyc + 1, 0, 0, 0);
      end
   endfunction

   task automatic set_table(input int a, input int b, input int c, input int d);
      tab[0] = a; tab[1] = b; tab[2] = c; tab[3] = d;
      for (int i = 0; i < N; i++) begin
         @(posedge clock); #1;
         bus.cfg_we = 1'b1; bus.cfg_addr = 2'(i); bus.cfg_data = 16'(tab[i]);
      end
      @(posedge clock); #1;
      bus.cfg_we = 1'b0;
   endtask

   task automatic defaults();
      loop_m = 1'b0; hold_s = 0; hold_len = 0; w_cyc = 0; w_addr = 0; w_data = 0;
      stop_cyc = 0; max_cyc = 20000;
   endtask

   task automatic run_seq(input string tag);
      cyc_t e;
      int m_en = 0, m_ir = 0, m_bz = 0, m_ph = 0, m_pd = 0, m_sd = 0, m_ce = 0, m_wn = 0, m_iv = 0;
      build_model();
      bus.loop_en = loop_m;
      @(posedge clock); #1;
      bus.start = 1'b1;
      for (int i = 1; i <= exp_q.size(); i++) begin
         @(posedge clock); #1;
         bus.start      = 1'b0;
         bus.hold       = hold_at(i);
         bus.ctr_switch = 1'($urandom_range(0, 1));
         bus.cfg_we     = (i == w_cyc);
         bus.cfg_addr   = 2'(w_addr);
         bus.cfg_data   = 16'(w_data);
         bus.stop       = (stop_cyc > 0) && (i == stop_cyc);
         @(negedge clock);
         e = exp_q[i-1];
         if (bus.ctr_enable !== e.en) m_en++;
         if (bus.ctr_interval_reset !== e.ireset) m_ir++;
         if (bus.busy !== e.busy) m_bz++;
         if (bus.phase !== e.phase) m_ph++;
         if (bus.phase_done !== e.pdone) m_pd++;
         if (bus.seq_done !== e.sdone) m_sd++;
         if (bus.cfg_err !== e.cerr) m_ce++;
         if (bus.warn !== (bus.ctr_switch & e.run)) m_wn++;
         if (bus.ctr_interval !== e.interval) m_iv++;
         if (i == hold_s) cnt_a = int'(cnt_q);
         if (i == hold_s + hold_len - 1) cnt_b = int'(cnt_q);
      end
      bus.hold = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0; bus.ctr_switch = 1'b0;
      check({tag, "_enable"},     m_en, 0);
      check({tag, "_ireset"},     m_ir, 0);
      check({tag, "_busy"},       m_bz, 0);
      check({tag, "_phase"},      m_ph, 0);
      check({tag, "_phase_done"}, m_pd, 0);
      check({tag, "_seq_done"},   m_sd, 0);
      check({tag, "_cfg_err"},    m_ce, 0);
      check({tag, "_warn"},       m_wn, 0);
      check({tag, "_interval"},   m_iv, 0);
   endtask

   initial begin
      bus.start = 0; bus.stop = 0; bus.hold = 0; bus.loop_en = 0; bus.cfg_we = 0;
      bus.cfg_addr = 0; bus.cfg_data = 0; bus.ctr_switch = 0;
      defaults();
      reset_n = 1'b0;
      #1;
      check("in_reset_ireset", bus.ctr_interval_reset, 1);
      check("in_reset_enable", bus.ctr_enable, 0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      check("rst_busy",     bus.busy, 0);
      check("rst_phase",    bus.phase, 0);
      check("rst_interval", bus.ctr_interval, 1);
      check("rst_pulses",   {bus.phase_done, bus.seq_done, bus.cfg_err}, 0);

      // Full non-loop sequence with mixed durations.
      defaults(); set_table(1, 2, 1, 1); run_seq("t1");

      // Zero entries skipped while looping; stopped mid-run.
      defaults(); set_table(1, 0, 0, 1); loop_m = 1'b1; stop_cyc = 260; max_cyc = 260;
      run_seq("t2");

      // All-zero table raises cfg_err.
      defaults(); set_table(0, 0, 0, 0); loop_m = 1'b1; run_seq("t3");

      // Hold mid phase 0 stretches the phase and freezes the count.
      defaults(); set_table(1, 1, 1, 1); hold_s = 30; hold_len = 10; run_seq("t4");
      check("t4_count_at_hold",  cnt_a, hold_s - 2);
      check("t4_count_held_end", cnt_b, hold_s - 2);

      // Rewrite the active phase during RUN; only the next pass sees it.
      defaults(); set_table(1, 1, 1, 1); loop_m = 1'b1; w_cyc = 10; w_addr = 0; w_data = 3;
      stop_cyc = 432; max_cyc = 432;
      run_seq("t5");

      // Stop on the terminal-count cycle suppresses phase_done.
      defaults(); set_table(1, 1, 1, 1); stop_cyc = 61; run_seq("t6");

      // Reset mid-RUN restores the table.
      defaults(); set_table(2, 1, 0, 1);
      @(posedge clock); #1 bus.start = 1'b1;
      @(posedge clock); #1 bus.start = 1'b0;
      repeat (20) @(posedge clock);
      @(negedge clock);
      check("mid_busy_before", bus.busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_interval", bus.ctr_interval, 1);
      check("mid_rst_ireset",   bus.ctr_interval_reset, 1);
      check("mid_rst_enable",   bus.ctr_enable, 0);
      check("mid_rst_busy",     bus.busy, 0);
      @(posedge clock); #1 reset_n = 1'b1;
      defaults(); tab[0] = 1; tab[1] = 1; tab[2] = 1; tab[3] = 1; run_seq("t7");

      // Randomized tables and hold windows.
      for (int k = 0; k < 5; k++) begin
         defaults();
         set_table(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         hold_s   = int'($urandom_range(1, 200));
         hold_len = int'($urandom_range(0, 15));
         run_seq("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
